// File: rtl/riscv_pkg.sv
// Shared RISC-V execution-unit types.
// mul_ope_e selects which multiply variant a mul_pipe request performs.
package riscv_pkg;

   typedef enum logic [1:0] {
      MULL   = 2'd0,   // low half, unsigned x unsigned (same bits as signed)
      MULH   = 2'd1,   // high half, signed x signed
      MULHSU = 2'd2,   // high half, signed a x unsigned b
      MULHU  = 2'd3    // high half, unsigned x unsigned
   } mul_ope_e;

endpackage

// File: rtl/mul_pipe.sv
// Pipelined integer multiplier with valid/ready on both sides.
// The product is formed from two half-width partial products. With more than
// one stage, they are registered in stage 0 and summed in stage 1. Any further
// stages only carry the selected result. With a single stage, everything is
// formed in one cycle. A stage advances when its successor is empty or
// advancing in the same cycle, so bubbles collapse.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (a, b, ope)
//   a, b                  operands (rs1, rs2)
//   ope                   MULL / MULH / MULHSU / MULHU
//   flush                 drop every in-flight request
//   out_valid / out_ready result handshake
//   out                   selected half of the 2*DATA_WIDTH product
module mul_pipe
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  mul_ope_e              ope,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out
);

   localparam int W  = DATA_WIDTH;
   localparam int H  = W / 2;
   localparam int PW = 2 * W;

   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] w_adv;
   logic [STAGES-1:0] w_load;
   logic              w_acc;

   logic              w_sa;
   logic              w_sb;
   logic              w_hi_in;
   logic [PW-1:0]     w_a_x;
   logic [PW-1:0]     w_b_lo;
   logic [PW-1:0]     w_b_hi;
   logic [PW-1:0]     w_pp_lo_in;
   logic [PW-1:0]     w_pp_hi_in;

   function automatic logic [W-1:0] f_sel(input logic [PW-1:0] p, input logic hi);
      return hi ? p[PW-1:W] : p[W-1:0];
   endfunction

   // Operands are extended to the full product width. Signed/unsigned then only
   // differ in the extension bits, and modulo-2^PW multiplication gives the exact
   // product for every variant. b is split into an unsigned low half and a
   // (possibly signed) high half.
   always_comb begin
      w_sa       = (ope == MULH) || (ope == MULHSU);
      w_sb       = (ope == MULH);
      w_hi_in    = (ope != MULL);
      w_a_x      = {{W{w_sa & a[W-1]}}, a};
      w_b_lo     = {{(PW-H){1'b0}}, b[H-1:0]};
      w_b_hi     = {{(PW-(W-H)){w_sb & b[W-1]}}, b[W-1:H]};
      w_pp_lo_in = w_a_x * w_b_lo;
      w_pp_hi_in = w_a_x * w_b_hi;
   end

   // Ready ripples back from the output: the last stage frees on out_ready,
   // each earlier stage frees when its successor is empty or freeing.
   always_comb begin
      w_adv = '0;
      w_adv[STAGES-1] = r_vld[STAGES-1] && out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         w_adv[k] = r_vld[k] && (!r_vld[k+1] || w_adv[k+1]);
      end
   end

   assign in_ready = !rst && !flush && (!r_vld[0] || w_adv[0]);
   assign w_acc    = in_valid && in_ready;

   always_comb begin
      w_load    = '0;
      w_load[0] = w_acc;
      for (int k = 1; k < STAGES; k++) begin
         w_load[k] = w_adv[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_vld <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= w_load[k] || (r_vld[k] && !w_adv[k]);
         end
      end
   end

   assign out_valid = r_vld[STAGES-1];

   // Data registers only load on a new entry, so out holds its last value
   // after the final result drains.
   generate
      if (STAGES == 1) begin : g_one
         logic [W-1:0] r_res0;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_res0 <= '0;
            end else if (w_load[0]) begin
               r_res0 <= f_sel(w_pp_lo_in + (w_pp_hi_in << H), w_hi_in);
            end
         end

         assign out = r_res0;
      end else begin : g_multi
         logic [PW-1:0] r_pp_lo;
         logic [PW-1:0] r_pp_hi;
         logic          r_hi;
         logic [W-1:0]  r_res [1:STAGES-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               r_pp_lo <= '0;
               r_pp_hi <= '0;
               r_hi    <= 1'b0;
            end else if (w_load[0]) begin
               r_pp_lo <= w_pp_lo_in;
               r_pp_hi <= w_pp_hi_in;
               r_hi    <= w_hi_in;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_res[1] <= '0;
            end else if (w_load[1]) begin
               r_res[1] <= f_sel(r_pp_lo + (r_pp_hi << H), r_hi);
            end
         end

         for (genvar k = 2; k < STAGES; k++) begin : g_carry
            always_ff @(posedge clk) begin
               if (rst) begin
                  r_res[k] <= '0;
               end else if (w_load[k]) begin
                  r_res[k] <= r_res[k-1];
               end
            end
         end

         assign out = r_res[STAGES-1];
      end
   endgenerate

endmodule

// File: tb/tb_mul_pipe.sv
module tb_mul_pipe;
   import riscv_pkg::*;

   localparam int W  = 32;
   localparam int ST = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   mul_ope_e      ope;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out;

   int errors = 0;
   int checks = 0;

   mul_pipe #(.DATA_WIDTH(W), .STAGES(ST)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .ope      (ope),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (out)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: full product by plain 64-bit arithmetic, then pick the half.
   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input mul_ope_e op);
      longint      p;
      logic [63:0] u;
      case (op)
         MULL:    u = 64'(x) * 64'(y);
         MULHU:   u = 64'(x) * 64'(y);
         MULH:    begin p = longint'($signed(x)) * longint'($signed(y)); u = p; end
         default: begin p = longint'($signed(x)) * longint'({32'b0, y}); u = p; end
      endcase
      return (op == MULL) ? u[31:0] : u[63:32];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      mul_ope_e    vop;
      logic [31:0] vexp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int lat;
      logic [31:0] exp_q[$];
      logic        prev_stall;
      logic [31:0] prev_out;
      logic [31:0] corner[5];
      logic [31:0] got;

      vecs[0]  = '{32'h00000007, 32'h00000006, MULL,   32'h0000002A};
      vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, MULH,   32'h00000000};
      vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, MULHU,  32'hFFFFFFFE};
      vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, MULL,   32'h00000001};
      vecs[4]  = '{32'hFFFFFFFF, 32'h00000002, MULHSU, 32'hFFFFFFFF};
      vecs[5]  = '{32'h80000000, 32'h80000000, MULH,   32'h40000000};
      vecs[6]  = '{32'h80000000, 32'h7FFFFFFF, MULH,   32'hC0000000};
      vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, MULHSU, 32'h80000000};
      vecs[8]  = '{32'h80000000, 32'h80000000, MULHU,  32'h40000000};
      vecs[9]  = '{32'h12345678, 32'h00000010, MULL,   32'h23456780};
      vecs[10] = '{32'hFFFFFFFF, 32'h00000005, MULH,   32'hFFFFFFFF};
      vecs[11] = '{32'h00000005, 32'hFFFFFFFF, MULHSU, 32'h00000004};
      corner   = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ope = MULL; flush = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      in_valid = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", out, 0);
      rst = 1'b0; in_valid = 1'b0;
      step();
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      step();

      // Single requests: value and latency.
      for (int i = 0; i < 12; i++) begin
         a = vecs[i].va; b = vecs[i].vb; ope = vecs[i].vop; in_valid = 1'b1; out_ready = 1'b1;
         #1;
         chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
         step();
         in_valid = 1'b0; a = $urandom; b = $urandom;
         lat = 1;
         while (!out_valid && lat < 20) begin
            step();
            lat++;
         end
         chk($sformatf("vec%0d_latency", i), lat, ST);
         chk($sformatf("vec%0d_out", i), out, vecs[i].vexp);
         step();
         chk($sformatf("vec%0d_drained", i), out_valid, 0);
      end

      // Back-to-back MULH, MULHU, MULL on all-ones operands.
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         ope = (j == 0) ? MULH : (j == 1) ? MULHU : MULL;
         #1;
         chk($sformatf("b2b_in_ready%0d", j), in_ready, 1);
         step();
      end
      in_valid = 1'b0;
      chk("b2b_v0", out_valid, 1); chk("b2b_o0", out, 32'h00000000); step();
      chk("b2b_v1", out_valid, 1); chk("b2b_o1", out, 32'hFFFFFFFE); step();
      chk("b2b_v2", out_valid, 1); chk("b2b_o2", out, 32'h00000001); step();
      chk("b2b_end", out_valid, 0);

      // Backpressure: capacity 3, fourth accepted as the first drains.
      out_ready = 1'b0; ope = MULL; in_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         a = 32'(j + 1); b = 32'(j + 3);
         #1;
         if (j < 3) chk($sformatf("bp_in_ready%0d", j), in_ready, 1);
         else       chk("bp_full_in_ready", in_ready, 0);
         if (j < 3) step();
      end
      chk("bp_full_out_valid", out_valid, 1);
      chk("bp_full_out", out, 3);
      step();
      #1;
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_out", out, 3);
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("bp_d1_v", out_valid, 1); chk("bp_d1", out, 8);  step();
      chk("bp_d2_v", out_valid, 1); chk("bp_d2", out, 15); step();
      chk("bp_d3_v", out_valid, 1); chk("bp_d3", out, 24); step();
      chk("bp_end", out_valid, 0);

      // Flush with two in flight and a third offered.
      out_ready = 1'b1; ope = MULL; in_valid = 1'b1;
      a = 7; b = 6; step();
      a = 3; b = 4; step();
      a = 5; b = 5; flush = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         chk($sformatf("flush_quiet%0d", j), out_valid, 0);
         step();
      end
      a = 9; b = 9; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("post_flush_latency", lat, ST);
      chk("post_flush_out", out, 81);
      step();

      // Reset with a full, stalled pipeline.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         a = 32'(100 + j); b = 32'(7); step();
      end
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      step();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out", out, 0);
      chk("midrst_release_in_ready", in_ready, 1);
      out_ready = 1'b1;
      step();
      for (int j = 0; j < 6; j++) begin
         chk($sformatf("midrst_quiet%0d", j), out_valid, 0);
         step();
      end

      // Random traffic against a FIFO model of accepted requests.
      prev_stall = 1'b0;
      prev_out   = '0;
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         a         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         ope       = mul_ope_e'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 99) < 70);
         flush     = ($urandom_range(0, 99) < 2);
         #1;
         if (prev_stall) begin
            chk("rnd_stall_valid", out_valid, 1);
            chk("rnd_stall_out", out, prev_out);
         end
         if (flush) chk("rnd_flush_in_ready", in_ready, 0);
         if (out_valid && exp_q.size() == 0) chk("rnd_spurious_valid", out_valid, 0);
         if (exp_q.size() == ST && !(out_valid && out_ready)) chk("rnd_capacity", in_ready, 0);
         if (out_valid && out_ready && exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk("rnd_out", out, got);
         end
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b, ope));
         prev_stall = out_valid && !out_ready && !flush;
         prev_out   = out;
         step();
      end

      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (out_valid && exp_q.size() == 0) chk("drain_spurious_valid", out_valid, 0);
         if (out_valid && exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk("drain_out", out, got);
         end
         step();
      end
      chk("drain_all_delivered", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
